serial_ripple_subtractor: RTL and testbench
===========================================

Name: serial_ripple_subtractor

Overview:
- Bit-serial two's-complement subtractor: computes diff = a - b - bin, one bit per clock, rippling the borrow through a single registered full-subtractor stage.
- Counterpart to the combinational ripple-carry adder in the adder library; it exercises the borrow path rather than the carry path.
- Trades latency for area.
- Uses valid/ready handshakes on both input and output so it can sit in a streaming arithmetic datapath.

Parameters:
- WIDTH, 4, operand and result width in bits (>= 2).
- CNT_W, $clog2(WIDTH), bit-index counter width (derived; do not override).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous reset, active-high.
- in_valid  input  1  operands presented.
- in_ready  output  1  block can accept operands.
- a  input  WIDTH  minuend.
- b  input  WIDTH  subtrahend.
- bin  input  1  borrow in.
- out_valid  output  1  result available.
- out_ready  input  1  consumer accepts result.
- diff  output  WIDTH  a - b - bin, modulo 2^WIDTH.
- bout  output  1  borrow out (1 when a < b + bin, unsigned).

Behaviour:
- Reset: all state clears on a clk edge with rst=1; rst is synchronous and active-high. After reset: state=IDLE, in_ready=1, out_valid=0, diff=0, bout=0, counter=0.
- FSM states are IDLE, RUN and DONE.
- IDLE:
  - in_ready=1.
  - When in_valid&&in_ready: latch a, b and bin into shift registers, set borrow register=bin, counter=0, go to RUN.
- RUN:
  - in_ready=0.
  - Each cycle, bit i (LSB first): d_i = a_i ^ b_i ^ br; br_next = (~a_i & b_i) | (~(a_i ^ b_i) & br).
  - d_i shifts into the diff register from the MSB side; operand registers shift right; counter increments.
  - After the cycle processing bit WIDTH-1: bout = final borrow, go to DONE.
- DONE:
  - out_valid=1; diff and bout held stable while out_valid && !out_ready.
  - On out_ready: go to IDLE.
  - in_ready stays 0 in DONE (no overlap). The new transaction is accepted no earlier than the cycle after the result handshake.
- Latency: out_valid rises exactly WIDTH cycles after the input handshake edge. Throughput is one result per WIDTH+2 cycles with out_ready held high.
- diff and bout keep their last values in IDLE; they are not cleared.
- Inputs a, b and bin are ignored except at the handshake edge. Changes during RUN have no effect.
- Wrap-around: the result is modulo 2^WIDTH. Examples: 0-1 gives diff=all ones, bout=1; a==b with bin=1 gives all ones, bout=1.
- rst asserted during RUN or DONE: returns to IDLE next edge, result discarded, out_valid=0, no partial result exposed.
- rst has priority over every handshake in the same cycle.

Optional Feature:
- Macro: SUB_OVERFLOW_FLAG_EN.
- Defined: adds output port ovf (1 bit). In DONE, ovf=1 iff the signed result overflowed, i.e. sign(a)!=sign(b) && sign(diff)!=sign(a), with bin included in the subtraction. ovf resets to 0 and is held with diff.
- Undefined: no ovf port, no associated logic.

Decomposition:
- Package sub_pkg:
  - state enum {IDLE, RUN, DONE}.
  - Localparam default WIDTH=4.
  - Function computing reference a-b-bin, for benches.
- Sub-module full_subtractor (combinational: a, b, bin -> d, bout) is instantiated once for the serial bit stage. It is reusable for a future combinational ripple-borrow subtractor.

Test Plan:
- Reset then a=5, b=3, bin=0, out_ready=1 -> out_valid exactly 4 cycles after accept; diff=4'd2, bout=0; in_ready returns 1 one cycle after the output handshake.
- a=3, b=5, bin=0 -> diff=4'hE, bout=1; a=8, b=8, bin=1 -> diff=4'hF, bout=1; a=0, b=0, bin=0 -> diff=0, bout=0.
- Back-pressure: a=9, b=4, out_ready=0 for 5 cycles -> out_valid held, diff=4'd5 stable, in_ready=0 throughout; in_valid pulses during the stall are ignored.
- rst asserted 2 cycles into RUN -> next edge IDLE, out_valid=0, in_ready=1; a fresh a=7, b=2 then yields diff=5.
- Exhaustive sweep over all 512 (a, b, bin) combinations with random out_ready -> every result matches the package reference; one result per handshake, none dropped or duplicated.
- With SUB_OVERFLOW_FLAG_EN: a=4'h8 (-8), b=1, bin=0 -> diff=4'h7, ovf=1; a=4'h7, b=4'hF (-1) -> diff=4'h8, ovf=1; a=5, b=3 -> ovf=0.

Source files
------------

// File: rtl/serial_ripple_subtractor_pkg.sv
// Shared types for the bit-serial subtractor: FSM state, default width, reference a-b-bin.
// Reference function returns {borrow, diff} in WIDTH+1 bits; the top bit is the unsigned borrow.
package sub_pkg;

    localparam int DEF_WIDTH = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic logic [DEF_WIDTH:0] ref_sub(
        input logic [DEF_WIDTH-1:0] x,
        input logic [DEF_WIDTH-1:0] y,
        input logic                 bi
    );
        return {1'b0, x} - {1'b0, y} - {{DEF_WIDTH{1'b0}}, bi};
    endfunction

endpackage

// File: rtl/serial_ripple_subtractor_fs.sv
// One-bit full subtractor: d = a - b - bin with borrow out; purely combinational.
// Zero latency, no flow control; shared by the serial stage and any future ripple-borrow array.
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = a ^ b ^ bin;
    assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_ripple_subtractor.sv
// Bit-serial a - b - bin, LSB first through one full_subtractor; SUB_OVERFLOW_FLAG_EN adds signed ovf.
// out_valid rises WIDTH cycles after accept; result held under out_ready=0, in_ready low until handshake.
module serial_ripple_subtractor
    import sub_pkg::*;
#(
    parameter  int WIDTH = DEF_WIDTH,
    localparam int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
`ifdef SUB_OVERFLOW_FLAG_EN
    output logic             ovf,
`endif
    output logic             bout
);

    state_t           state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] d_sh;
    logic [WIDTH-1:0] d_nxt;
    logic             br;
    logic [CNT_W-1:0] cnt;
    logic             d_bit;
    logic             br_next;
`ifdef SUB_OVERFLOW_FLAG_EN
    logic             a_msb;
    logic             b_msb;
`endif

    full_subtractor u_fs (
        .a    (a_sh[0]),
        .b    (b_sh[0]),
        .bin  (br),
        .d    (d_bit),
        .bout (br_next)
    );

    // New bit enters from the MSB side so the final shift leaves bit 0 in place.
    assign d_nxt = (d_sh >> 1) | (WIDTH'(d_bit) << (WIDTH - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            diff      <= '0;
            bout      <= 1'b0;
            cnt       <= '0;
            a_sh      <= '0;
            b_sh      <= '0;
            d_sh      <= '0;
            br        <= 1'b0;
`ifdef SUB_OVERFLOW_FLAG_EN
            ovf       <= 1'b0;
            a_msb     <= 1'b0;
            b_msb     <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        a_sh     <= a;
                        b_sh     <= b;
                        br       <= bin;
                        cnt      <= '0;
                        in_ready <= 1'b0;
                        state    <= RUN;
`ifdef SUB_OVERFLOW_FLAG_EN
                        a_msb    <= a[WIDTH-1];
                        b_msb    <= b[WIDTH-1];
`endif
                    end
                end
                RUN: begin
                    a_sh <= a_sh >> 1;
                    b_sh <= b_sh >> 1;
                    br   <= br_next;
                    d_sh <= d_nxt;
                    cnt  <= cnt + 1'b1;
                    if (cnt == CNT_W'(WIDTH - 1)) begin
                        diff      <= d_nxt;
                        bout      <= br_next;
                        out_valid <= 1'b1;
                        state     <= DONE;
`ifdef SUB_OVERFLOW_FLAG_EN
                        ovf       <= (a_msb != b_msb) && (d_bit != a_msb);
`endif
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_ripple_subtractor.sv
// Directed and exhaustive bench for serial_ripple_subtractor (WIDTH=4); ovf checks when SUB_OVERFLOW_FLAG_EN is set.
module tb_serial_ripple_subtractor;
    import sub_pkg::*;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] diff;
    logic         bout;
`ifdef SUB_OVERFLOW_FLAG_EN
    logic         ovf;
`endif

    int n_assert = 0;
    int n_fail   = 0;

    serial_ripple_subtractor #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .bin       (bin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff      (diff),
`ifdef SUB_OVERFLOW_FLAG_EN
        .ovf       (ovf),
`endif
        .bout      (bout)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_assert++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    // Accepts one operand set, scrambles inputs during RUN, and checks latency and result.
    task automatic txn(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic tbin,
                       input logic [W-1:0] ed, input logic eb, input string tag);
        int lat;
        a = ta;
        b = tb_v;
        bin = tbin;
        in_valid = 1'b1;
        lat = 0;
        while (!in_ready && lat < 20) begin
            tick();
            lat++;
        end
        tick();
        in_valid = 1'b0;
        a = ~ta;
        b = ~tb_v;
        bin = ~tbin;
        chk({tag, "_in_ready_busy"}, in_ready, 0);
        lat = 0;
        while (!out_valid && lat < 3 * W) begin
            tick();
            lat++;
        end
        chk({tag, "_latency"}, lat, W);
        chk({tag, "_diff"}, diff, ed);
        chk({tag, "_bout"}, bout, eb);
    endtask

    initial begin
        logic [W:0]   r;
        logic [W-1:0] ta;
        logic [W-1:0] tb_v;
        logic         tbin;
        int           guard;
        int           hs;
        logic         got;

        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        a = '0;
        b = '0;
        bin = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_diff", diff, 0);
        chk("rst_bout", bout, 0);

        // 5 - 3 with out_ready held high
        out_ready = 1'b1;
        txn(4'd5, 4'd3, 1'b0, 4'd2, 1'b0, "t5m3");
        tick();
        chk("t5m3_in_ready_after", in_ready, 1);
        chk("t5m3_out_valid_after", out_valid, 0);
        chk("t5m3_diff_held", diff, 4'd2);

        txn(4'd3, 4'd5, 1'b0, 4'hE, 1'b1, "t3m5");
        tick();
        txn(4'd8, 4'd8, 1'b1, 4'hF, 1'b1, "t8m8b");
        tick();
        txn(4'd0, 4'd0, 1'b0, 4'h0, 1'b0, "t0m0");
        tick();
        txn(4'd0, 4'd1, 1'b0, 4'hF, 1'b1, "t0m1");
        tick();

        // Back-pressure with ignored in_valid pulses
        out_ready = 1'b0;
        txn(4'd9, 4'd4, 1'b0, 4'd5, 1'b0, "bp");
        for (int k = 0; k < 5; k++) begin
            in_valid = k[0];
            a = 4'd1;
            b = 4'd1;
            tick();
            chk("bp_out_valid_held", out_valid, 1);
            chk("bp_diff_stable", diff, 4'd5);
            chk("bp_in_ready_low", in_ready, 0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        chk("bp_in_ready_after", in_ready, 1);
        chk("bp_out_valid_after", out_valid, 0);
        for (int k = 0; k < W + 2; k++) tick();
        chk("bp_no_phantom", out_valid, 0);

        // Reset two cycles into RUN
        a = 4'd12;
        b = 4'd1;
        bin = 1'b0;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_in_ready", in_ready, 1);
        chk("midrst_diff", diff, 0);
        for (int k = 0; k < W + 1; k++) tick();
        chk("midrst_no_result", out_valid, 0);
        txn(4'd7, 4'd2, 1'b0, 4'd5, 1'b0, "t7m2");
        tick();

`ifdef SUB_OVERFLOW_FLAG_EN
        txn(4'h8, 4'h1, 1'b0, 4'h7, 1'b0, "ovf_n8m1");
        chk("ovf_n8m1_flag", ovf, 1);
        tick();
        txn(4'h7, 4'hF, 1'b0, 4'h8, 1'b1, "ovf_7mn1");
        chk("ovf_7mn1_flag", ovf, 1);
        tick();
        txn(4'd5, 4'd3, 1'b0, 4'd2, 1'b0, "ovf_5m3");
        chk("ovf_5m3_flag", ovf, 0);
        tick();
`endif

        // Exhaustive sweep with random back-pressure
        hs = 0;
        for (int i = 0; i < 512; i++) begin
            {ta, tb_v, tbin} = 9'(i);
            r = ref_sub(ta, tb_v, tbin);
            chk("sweep_idle_out_valid", out_valid, 0);
            a = ta;
            b = tb_v;
            bin = tbin;
            in_valid = 1'b1;
            guard = 0;
            while (!in_ready && guard < 20) begin
                tick();
                guard++;
            end
            tick();
            in_valid = 1'b0;
            got = 1'b0;
            guard = 0;
            while (!got && guard < 100) begin
                out_ready = 1'($urandom_range(0, 1));
                if (out_valid && out_ready) begin
                    chk("sweep_diff", diff, r[W-1:0]);
                    chk("sweep_bout", bout, r[W]);
                    hs++;
                    got = 1'b1;
                end
                tick();
                guard++;
            end
            chk("sweep_handshake", got, 1);
        end
        out_ready = 1'b0;
        chk("sweep_count", hs, 512);
        tick();
        chk("sweep_no_dup", out_valid, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
